// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM arbiter slice.
package vram_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned RD_LATENCY = 2;

    typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CPU} own_e;

endpackage

// File: rtl/vram_rd_pipe.sv
// Read-return path: owner tags follow each issued read until mem_rdata is due,
// then the word is registered onto the owning requester's port.
module vram_rd_pipe
    import vram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        issue_own,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid
);

    // tag_q[0] is aligned with the issue cycle, the last stage with mem_rdata.
    own_e tag_q [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= OWN_NONE;
            end
            vga_rdata  <= '0;
            vga_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            tag_q[0] <= own_e'(issue_own);
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            vga_rvalid <= (tag_q[RD_LATENCY-1] == OWN_VGA);
            cpu_rvalid <= (tag_q[RD_LATENCY-1] == OWN_CPU);
            if (tag_q[RD_LATENCY-1] == OWN_VGA) begin
                vga_rdata <= mem_rdata;
            end
            if (tag_q[RD_LATENCY-1] == OWN_CPU) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// VGA-priority arbiter for a single-port VRAM shared with the CPU.
// Define VRAM_ARB_STATS_EN to build the CPU stall-cycle counter.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       cpu_stall_cnt
);

    logic       sel_vga;
    logic       sel_cpu;
    logic [1:0] issue_own;

    // The ack cycle blocks a re-grant so a held request is not issued twice.
    assign sel_vga = vga_req;
    assign sel_cpu = !vga_req && cpu_req && !cpu_ack;

    always_comb begin
        issue_own = OWN_NONE;
        if (sel_vga) begin
            issue_own = OWN_VGA;
        end else if (sel_cpu && !cpu_we) begin
            issue_own = OWN_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
        end else begin
            mem_en  <= sel_vga || sel_cpu;
            mem_we  <= sel_cpu && cpu_we;
            cpu_ack <= sel_cpu;
            if (sel_vga) begin
                mem_addr <= vga_addr;
            end else if (sel_cpu) begin
                mem_addr <= cpu_addr;
            end
            if (sel_cpu && cpu_we) begin
                mem_wdata <= cpu_wdata;
            end
        end
    end

    vram_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .issue_own  (issue_own),
        .mem_rdata  (mem_rdata),
        .vga_rdata  (vga_rdata),
        .vga_rvalid (vga_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid)
    );

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (cpu_req && !cpu_ack && !sel_cpu && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign cpu_stall_cnt = stall_q;
`else
    assign cpu_stall_cnt = '0;
`endif

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the VGA scan-out pixel fetch and the 16-bit CPU's load/store port.
- VGA fetches have absolute priority, because they carry a pixel deadline. CPU accesses fill the free slots.
- Sits between the VGA timing/display block (50 MHz clk, one pixel every 2 clk) and the VRAM macro.
- All memory-side outputs are registered. Read data returns through a tagged 2-stage pipeline.

Parameters:
- ADDR_W, 16, VRAM word-address width
- DATA_W, 16, VRAM word width

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- vga_req  in  1  one-cycle fetch request from scan-out
- vga_addr  in  ADDR_W  fetch address, valid with vga_req
- vga_rdata  out  DATA_W  fetched pixel word
- vga_rvalid  out  1  vga_rdata valid, one-cycle pulse
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  access issued to memory, one-cycle pulse
- cpu_rdata  out  DATA_W  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse
- mem_en  out  1  VRAM access enable
- mem_we  out  1  VRAM write enable
- mem_addr  out  ADDR_W  VRAM address
- mem_wdata  out  DATA_W  VRAM write data
- mem_rdata  in  DATA_W  VRAM read data, valid the cycle after mem_en with mem_we=0
- cpu_stall_cnt  out  16  CPU wait-cycle counter (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; pipeline tags cleared to OWN_NONE.
- Arbitration, evaluated every cycle t on sampled inputs:
  - vga_req=1: issue VGA read.
  - else cpu_req=1 and cpu_ack=0: issue CPU access.
  - else idle.
- Issue happens in cycle t+1, with registered mem_en/mem_we/mem_addr/mem_wdata. mem_we=1 only for a CPU write.
- cpu_ack pulses in cycle t+1 together with the issued CPU access.
- While cpu_ack=1, the CPU is not re-granted. The CPU may drop cpu_req or present a new request from cycle t+2.
- Read tag pipeline: the owner (OWN_VGA / OWN_CPU) is recorded at issue (t+1) and shifted through 2 stages.
- At t+3, mem_rdata from t+2 is registered onto vga_rdata/vga_rvalid or cpu_rdata/cpu_rvalid according to the tag.
- Latency: vga_req to vga_rvalid is exactly 3 cycles; a CPU read's cpu_ack to cpu_rvalid is exactly 2 cycles.
- CPU writes produce no rvalid.
- Throughput: 1 access per cycle; back-to-back VGA requests are all served.
- rdata registers hold their last value when rvalid=0.
- vga_req and cpu_req in the same cycle: VGA issued, CPU waits. No starvation, since scan-out requests at most every 2nd cycle.
- Consecutive vga_req cycles: each issued, CPU held off for the whole run.
- cpu_req dropped before cpu_ack: request withdrawn, no access.
- Reset mid-operation: in-flight tags cleared; no rvalid pulses for accesses issued before reset; mem_en=0 the cycle after reset is sampled.
- Address/data are passed through unmodified; there is no address wrap logic.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined: cpu_stall_cnt increments by 1, saturating at 16'hFFFF, each cycle where cpu_req=1, cpu_ack=0 and the arbiter did not select the CPU. It clears on rst.
- Not defined: cpu_stall_cnt is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package vram_pkg: ADDR_W/DATA_W defaults, owner typedef {OWN_NONE, OWN_VGA, OWN_CPU}, RD_LATENCY=2 constant.
- Sub-module vram_rd_pipe: 2-stage owner-tag delay line plus output demux/registering of mem_rdata.

Test Plan:
- Isolated VGA read: vga_req with addr 0x0010, mem model returns 0xABCD → mem_en at t+1, vga_rvalid=1 and vga_rdata=0xABCD at t+3; cpu outputs stay 0.
- CPU write then read: write 0x1234 to 0x0200, then read 0x0200 → cpu_ack once per access, mem_we=1 only on the write; cpu_rvalid with 0x1234 exactly 2 cycles after the read's ack.
- Collision: vga_req (0x0001) and cpu_req read (0x0002) in the same cycle → VGA issued at t+1, CPU ack at t+2, vga_rvalid at t+3, cpu_rvalid at t+4.
- Scan-out pattern: vga_req every 2nd cycle for 640 requests with cpu_req held high → every VGA latency is 3, and the CPU is acked in each gap cycle. With VRAM_ARB_STATS_EN, stall count equals the number of VGA-blocked cycles.
- Held request: cpu_req kept high through ack → no duplicate grant in the ack cycle; the second access is acked no earlier than t+3.
- Reset with 2 reads in flight → no vga_rvalid/cpu_rvalid afterwards; all outputs 0 the cycle after rst.
